// File: rtl/game_pkg.sv
// Shared definitions for the number-guessing game controller: FSM state encoding,
// LFSR tap positions and the seed used in place of an all-zero seed.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StWaitGuess,
    StCheck,
    StRoundEnd,
    StOver
  } game_state_e;

  // Taps for x^6 + x^5 + 1; feedback bit is q[5] ^ q[4]
  localparam int unsigned LfsrTapHi = 5;
  localparam int unsigned LfsrTapLo = 4;

  // An all-zero LFSR would lock up, so a zero seed is replaced by this value
  localparam logic [5:0] SeedSubst = 6'b000001;

endpackage

// File: rtl/prbs6_lfsr.sv
// Fibonacci LFSR producing the per-round targets; load has priority over step.
module prbs6_lfsr
  import game_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic         clock,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? N'(SeedSubst) : seed;
    end else if (step) begin
      q_d = {q_q[N-2:0], q_q[LfsrTapHi] ^ q_q[LfsrTapLo]};
    end
  end

  // load doubles as the reset path, so no separate reset is needed here
  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/game_ctrl.sv
// Guessing-game controller: draws a target per round from the LFSR, grades guesses,
// and tracks tries, rounds and score until the game is over.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N         = 6,
  parameter int unsigned ROUNDS    = 8,
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic         clock,
  input  logic         new_Game,
  input  logic [N-1:0] pdata6,
  input  logic         start,
  input  logic         guess_valid,
  input  logic [N-1:0] guess,
  output logic         guess_ready,
  output logic         hit,
  output logic         high,
  output logic         low,
  output logic         miss,
  output logic [3:0]   score,
  output logic [3:0]   round,
  output logic [2:0]   tries,
  output logic         game_over,
  output logic [N-1:0] prbs_out
);

  localparam logic [3:0] RoundsW   = 4'(ROUNDS);
  localparam logic [2:0] MaxTriesW = 3'(MAX_TRIES);

  game_state_e  state_q, state_d;
  logic [N-1:0] guess_q, guess_d;
  logic [3:0]   score_q, score_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   tries_q, tries_d;
  logic [N-1:0] target;
  logic [2:0]   tries_inc;
  logic [3:0]   round_inc;
  logic         is_hit, is_high, is_low;
  logic         out_of_tries;
  logic         lfsr_step;

  prbs6_lfsr #(
    .N(N)
  ) u_lfsr (
    .clock(clock),
    .load (new_Game),
    .step (lfsr_step),
    .seed (pdata6),
    .q    (target)
  );

  assign lfsr_step    = (state_q == StDraw) & ~new_Game;
  assign tries_inc    = tries_q + 3'd1;
  assign round_inc    = round_q + 4'd1;
  assign is_hit       = (guess_q == target);
  assign is_high      = (guess_q > target);
  assign is_low       = (guess_q < target);
  assign out_of_tries = ~is_hit & (tries_inc == MaxTriesW);

  // State register
  always_ff @(posedge clock) begin
    if (new_Game) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start) state_d = StDraw;
      StDraw:      state_d = StWaitGuess;
      StWaitGuess: if (guess_valid) state_d = StCheck;
      StCheck:     state_d = (is_hit || out_of_tries) ? StRoundEnd : StWaitGuess;
      StRoundEnd:  state_d = (round_inc == RoundsW) ? StOver : StDraw;
      StOver:      state_d = StOver;
      default:     state_d = StIdle;
    endcase
  end

  // Datapath next-state: guess latch, tries, score and round counters
  always_comb begin
    guess_d = guess_q;
    score_d = score_q;
    round_d = round_q;
    tries_d = tries_q;
    unique case (state_q)
      StDraw:      tries_d = 3'd0;
      StWaitGuess: if (guess_valid) guess_d = guess;
      StCheck: begin
        tries_d = tries_inc;
        if (is_hit && (score_q != RoundsW)) score_d = score_q + 4'd1;
      end
      StRoundEnd:  round_d = round_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (new_Game) begin
      guess_q <= '0;
      score_q <= 4'd0;
      round_q <= 4'd0;
      tries_q <= 3'd0;
    end else begin
      guess_q <= guess_d;
      score_q <= score_d;
      round_q <= round_d;
      tries_q <= tries_d;
    end
  end

  // Outputs decoded from the current state; grading pulses exist only in StCheck
  always_comb begin
    guess_ready = 1'b0;
    hit         = 1'b0;
    high        = 1'b0;
    low         = 1'b0;
    miss        = 1'b0;
    game_over   = 1'b0;
    unique case (state_q)
      StWaitGuess: guess_ready = 1'b1;
      StCheck: begin
        hit  = is_hit;
        high = is_high;
        low  = is_low;
        miss = out_of_tries;
      end
      StOver:      game_over = 1'b1;
      default: ;
    endcase
  end

  assign score    = score_q;
  assign round    = round_q;
  assign tries    = tries_q;
  assign prbs_out = target;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected grades are queued when a guess is driven
// and compared when the controller pulses hit/high/low/miss.
module tb_game_ctrl;

  localparam int unsigned N         = 6;
  localparam int unsigned ROUNDS    = 8;
  localparam int unsigned MAX_TRIES = 7;

  logic         clock = 1'b0;
  logic         new_Game = 1'b0;
  logic [N-1:0] pdata6 = '0;
  logic         start = 1'b0;
  logic         guess_valid = 1'b0;
  logic [N-1:0] guess = '0;
  logic         guess_ready, hit, high, low, miss, game_over;
  logic [3:0]   score, round;
  logic [2:0]   tries;
  logic [N-1:0] prbs_out;

  always #5 clock = ~clock;

  game_ctrl #(
    .N        (N),
    .ROUNDS   (ROUNDS),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clock      (clock),
    .new_Game   (new_Game),
    .pdata6     (pdata6),
    .start      (start),
    .guess_valid(guess_valid),
    .guess      (guess),
    .guess_ready(guess_ready),
    .hit        (hit),
    .high       (high),
    .low        (low),
    .miss       (miss),
    .score      (score),
    .round      (round),
    .tries      (tries),
    .game_over  (game_over),
    .prbs_out   (prbs_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  sb_q[$];
  logic [3:0]  sb_exp;
  logic [5:0]  model_lfsr;
  int unsigned tries_m;
  bit          ended;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] lfsr_next(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Grade monitor: every pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (hit || high || low || miss) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'({hit, high, low, miss}), 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("grade", 32'({hit, high, low, miss}), 32'(sb_exp));
      end
    end
  end

  task automatic do_reset(input logic [5:0] seed);
    new_Game    = 1'b1;
    pdata6      = seed;
    start       = 1'b0;
    guess_valid = 1'b0;
    tick();
    new_Game   = 1'b0;
    model_lfsr = (seed == 6'd0) ? 6'd1 : seed;
    tries_m    = 0;
    check("rst_ready", 32'(guess_ready), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_round", 32'(round), 32'd0);
    check("rst_tries", 32'(tries), 32'd0);
    check("rst_pulses", 32'({hit, high, low, miss}), 32'd0);
    check("rst_prbs", 32'(prbs_out), 32'(model_lfsr));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!guess_ready && n < 12) begin
      tick();
      n++;
    end
    if (!guess_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic begin_round();
    model_lfsr = lfsr_next(model_lfsr);
    tries_m    = 0;
    wait_ready();
    check("target", 32'(prbs_out), 32'(model_lfsr));
  endtask

  // Returns in the cycle the controller is grading the guess
  task automatic play_guess(input logic [5:0] g, output bit round_done);
    bit h, hi, lo, m;
    wait_ready();
    check("tries_before", 32'(tries), tries_m);
    h  = (g == model_lfsr);
    hi = (g > model_lfsr);
    lo = (g < model_lfsr);
    m  = !h && (tries_m + 1 == MAX_TRIES);
    sb_q.push_back({h, hi, lo, m});
    guess       = g;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tries_m++;
    round_done = h | m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] wrong[7];
    logic [5:0] tbl[4];
    wrong = '{6'd0, 6'd63, 6'd1, 6'd62, 6'd2, 6'd60, 6'd3};
    tbl   = '{6'b001000, 6'b010000, 6'b100001, 6'b000011};

    // Game 1: seed 1, scripted first rounds then a miss round
    do_reset(6'b000001);
    do_start();
    begin_round();
    check("first_target", 32'(prbs_out), 32'h02);
    play_guess(6'd5, ended);
    play_guess(6'd1, ended);
    play_guess(6'd2, ended);
    check("r1_ended", 32'(ended), 32'd1);
    tick();
    tick();
    check("r1_score", 32'(score), 32'd1);
    check("r1_round", 32'(round), 32'd1);
    check("r1_tries", 32'(tries), 32'd3);

    begin_round();
    check("r2_target", 32'(prbs_out), 32'h04);
    for (int i = 0; i < 7; i++) play_guess(wrong[i], ended);
    check("r2_ended", 32'(ended), 32'd1);
    tick();
    tick();
    check("r2_score", 32'(score), 32'd1);
    check("r2_round", 32'(round), 32'd2);
    check("r2_tries", 32'(tries), 32'd7);

    for (int i = 0; i < 4; i++) begin
      begin_round();
      check("tbl_target", 32'(prbs_out), 32'(tbl[i]));
      play_guess(6'd63, ended);
      play_guess(model_lfsr, ended);
    end
    for (int i = 0; i < 2; i++) begin
      begin_round();
      play_guess(model_lfsr, ended);
    end
    tick();
    tick();
    check("g1_over", 32'(game_over), 32'd1);
    check("g1_score", 32'(score), 32'd7);
    check("g1_round", 32'(round), 32'd8);
    check("g1_ready", 32'(guess_ready), 32'd0);

    // Game 2: all rounds won, then inputs ignored in the over state
    do_reset(6'h2A);
    do_start();
    for (int r = 0; r < 8; r++) begin
      begin_round();
      play_guess(model_lfsr, ended);
    end
    tick();
    tick();
    check("g2_over", 32'(game_over), 32'd1);
    check("g2_score", 32'(score), 32'd8);
    check("g2_round", 32'(round), 32'd8);
    start       = 1'b1;
    guess_valid = 1'b1;
    guess       = model_lfsr;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_over", 32'(game_over), 32'd1);
      check("hold_ready", 32'(guess_ready), 32'd0);
      check("hold_score", 32'(score), 32'd8);
      check("hold_round", 32'(round), 32'd8);
      check("hold_tries", 32'(tries), 32'd1);
    end
    start       = 1'b0;
    guess_valid = 1'b0;

    // Game 3: zero seed, then abort with new_Game during a guess offer
    do_reset(6'b000000);
    do_start();
    begin_round();
    check("zero_seed_target", 32'(prbs_out), 32'h02);
    play_guess(model_lfsr, ended);
    begin_round();
    new_Game    = 1'b1;
    pdata6      = 6'h15;
    guess_valid = 1'b1;
    guess       = model_lfsr;
    tick();
    new_Game    = 1'b0;
    guess_valid = 1'b0;
    model_lfsr  = 6'h15;
    check("abort_ready", 32'(guess_ready), 32'd0);
    check("abort_score", 32'(score), 32'd0);
    check("abort_round", 32'(round), 32'd0);
    check("abort_tries", 32'(tries), 32'd0);
    check("abort_pulses", 32'({hit, high, low, miss}), 32'd0);
    check("abort_prbs", 32'(prbs_out), 32'h15);
    tick();
    check("abort_idle_pulses", 32'({hit, high, low, miss}), 32'd0);
    check("abort_idle_ready", 32'(guess_ready), 32'd0);
    do_start();
    begin_round();
    play_guess(model_lfsr, ended);
    tick();
    tick();
    check("restart_score", 32'(score), 32'd1);
    check("restart_round", 32'(round), 32'd1);

    tick();
    tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
